// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ message sources.
// Round-robin arbitration at message granularity; a grant is held until the
// byte flagged last has fully left the UART, so messages never interleave.
// Optional macro UART_ARB_TIMEOUT_EN: force-release a granted requester that
// stalls for TIMEOUT cycles and pulse timeout_err. Without it timeout_err is 0.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy,
    output logic                 tx_latch,
    output logic [7:0]           tx_data,
    input  logic                 tx_empty,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               r_state, w_state_n;
    logic [IDX_W-1:0]     r_ptr, w_ptr_n;
    logic [IDX_W-1:0]     r_grant_idx, w_grant_idx_n;
    logic                 r_grant_valid, w_grant_valid_n;
    logic                 r_busy, w_busy_n;
    logic                 r_tx_latch, w_tx_latch_n;
    logic [7:0]           r_tx_data, w_tx_data_n;
    logic [NUM_REQ-1:0]   r_req_ack, w_req_ack_n;
    logic                 r_last, w_last_n;
    logic [1:0]           r_guard, w_guard_n;
    logic                 r_timeout_err, w_timeout_err_n;

    logic [IDX_W:0]       w_pick;
    logic                 w_req_g;
    logic                 w_last_g;
    logic [7:0]           w_byte_g;
    logic [NUM_REQ-1:0]   w_ack_onehot;
    logic                 w_stall_hit;

    // First set request scanning cyclically from p; returns {hit, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
        logic [IDX_W:0] res;
        int             best;
        int             d;
        res  = '0;
        best = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(p);
            if (d < 0) begin
                d = d + NUM_REQ;
            end else begin
                d = d;
            end
            if (r[i] && (d < best)) begin
                best = d;
                res  = {1'b1, IDX_W'(i)};
            end else begin
                res  = res;
            end
        end
        return res;
    endfunction

    // Successor of a requester index, wrapping at NUM_REQ-1.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= NUM_REQ - 1) begin
            return '0;
        end else begin
            return i + IDX_W'(1);
        end
    endfunction

    assign w_pick       = rr_pick(req, r_ptr);
    assign w_req_g      = req[r_grant_idx];
    assign w_last_g     = req_last[r_grant_idx];
    assign w_byte_g     = req_data[{r_grant_idx, 3'b000} +: 8];
    assign w_ack_onehot = NUM_REQ'(1) << r_grant_idx;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] r_stall;

    assign w_stall_hit = (r_state == ST_SEND) && !w_req_g &&
                         (r_stall == 16'(TIMEOUT - 1));

    // Stall counter: zero outside SEND (covers SEND entry and every ack),
    // counts only cycles where the granted requester has nothing to offer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= 16'd0;
        end else if (r_state != ST_SEND) begin
            r_stall <= 16'd0;
        end else if (!w_req_g) begin
            r_stall <= r_stall + 16'd1;
        end else begin
            r_stall <= r_stall;
        end
    end
`else
    // A stalled requester keeps the grant; TIMEOUT only qualifies as a constant.
    localparam logic TIMEOUT_IN_RANGE = (TIMEOUT > 0) && (TIMEOUT < 65536);
    assign w_stall_hit = 1'b0 & TIMEOUT_IN_RANGE;
`endif

    // Next-state and next-output logic for the arbitration/handshake FSM.
    always_comb begin
        w_state_n       = r_state;
        w_ptr_n         = r_ptr;
        w_grant_idx_n   = r_grant_idx;
        w_grant_valid_n = r_grant_valid;
        w_tx_latch_n    = 1'b0;
        w_tx_data_n     = r_tx_data;
        w_req_ack_n     = '0;
        w_last_n        = r_last;
        w_guard_n       = r_guard;
        w_timeout_err_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[IDX_W]) begin
                    w_grant_idx_n   = w_pick[IDX_W-1:0];
                    w_grant_valid_n = 1'b1;
                    w_state_n       = ST_SEND;
                end else begin
                    w_state_n       = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_req_g && tx_empty) begin
                    w_tx_data_n  = w_byte_g;
                    w_tx_latch_n = 1'b1;
                    w_req_ack_n  = w_ack_onehot;
                    w_last_n     = w_last_g;
                    w_guard_n    = 2'd2;
                    w_state_n    = ST_GUARD;
                end else if (w_stall_hit) begin
                    w_timeout_err_n = 1'b1;
                    w_grant_valid_n = 1'b0;
                    w_ptr_n         = next_idx(r_grant_idx);
                    w_state_n       = ST_IDLE;
                end else begin
                    w_state_n    = ST_SEND;
                end
            end
            ST_GUARD: begin
                // Give the UART time to drop tx_empty before trusting it again.
                w_guard_n = r_guard - 2'd1;
                if (r_guard <= 2'd1) begin
                    w_state_n = ST_DRAIN;
                end else begin
                    w_state_n = ST_GUARD;
                end
            end
            ST_DRAIN: begin
                if (tx_empty) begin
                    if (r_last) begin
                        w_grant_valid_n = 1'b0;
                        w_ptr_n         = next_idx(r_grant_idx);
                        w_state_n       = ST_IDLE;
                    end else begin
                        w_state_n       = ST_SEND;
                    end
                end else begin
                    w_state_n = ST_DRAIN;
                end
            end
            default: begin
                w_grant_valid_n = 1'b0;
                w_state_n       = ST_IDLE;
            end
        endcase
        w_busy_n = (w_state_n != ST_IDLE);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_latch    <= 1'b0;
            r_tx_data     <= 8'd0;
            r_req_ack     <= '0;
            r_last        <= 1'b0;
            r_guard       <= 2'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_ptr         <= w_ptr_n;
            r_grant_idx   <= w_grant_idx_n;
            r_grant_valid <= w_grant_valid_n;
            r_busy        <= w_busy_n;
            r_tx_latch    <= w_tx_latch_n;
            r_tx_data     <= w_tx_data_n;
            r_req_ack     <= w_req_ack_n;
            r_last        <= w_last_n;
            r_guard       <= w_guard_n;
            r_timeout_err <= w_timeout_err_n;
        end
    end

    assign req_ack     = r_req_ack;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign busy        = r_busy;
    assign tx_latch    = r_tx_latch;
    assign tx_data     = r_tx_data;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ message sources inside m3_ice_top, e.g. per-bus response generators and the event/snoop reporter.
- Arbitration is round-robin at message granularity. A grant is held until the requester's byte flagged last has fully left the UART.
- Drives the UART tx_latch/tx_data/tx_empty handshake directly, so bytes from different messages never interleave on USB_UART_TXD.

Parameters:
NUM_REQ, 4, number of requesters (2..8, need not be a power of two)
IDX_W, 2, width of grant index; must satisfy 2**IDX_W >= NUM_REQ
TIMEOUT, 50000, clk cycles a granted requester may stall before forced release (macro-gated)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester "byte valid"; held until acked
req_data  in  NUM_REQ*8  flattened bytes; requester i at [8*i+7:8*i]
req_last  in  NUM_REQ  current byte is the final byte of its message
req_ack  out  NUM_REQ  one-cycle pulse: byte consumed; requester presents next byte or drops req
grant_valid  out  1  a message is in progress
grant_idx  out  IDX_W  index of granted requester
busy  out  1  state != IDLE
tx_latch  out  1  one-cycle load strobe to UART
tx_data  out  8  registered byte to UART, stable from tx_latch until next load
tx_empty  in  1  UART transmitter idle
timeout_err  out  1  one-cycle pulse on forced release; constant 0 without macro

Behaviour:
- Reset values (asynchronous): state=IDLE, all outputs 0, rr pointer=0. Reset mid-message drops tx_latch immediately; no ack is issued for an interrupted byte.
- IDLE:
  - Any req set: select the first set bit scanning cyclically from the pointer (pointer, pointer+1, ..., wrapping at NUM_REQ-1 -> 0).
  - Next edge: grant_idx<=sel, grant_valid<=1, state->SEND.
  - No req: remain in IDLE.
- SEND, granted index g:
  - When req[g]=1 and tx_empty=1, next edge sets tx_data<=req_data[g], tx_latch<=1, req_ack[g]<=1, last_r<=req_last[g], guard counter<=2, state->GUARD.
  - Otherwise hold in SEND.
  - req on other indices is ignored while granted.
- GUARD: tx_latch and req_ack return to 0 after exactly one cycle. Counter decrements; at 0 state->DRAIN. This masks the UART's tx_empty deassert latency.
- DRAIN: wait for tx_empty=1, then:
  - last_r=1: grant_valid<=0, pointer<=(g+1) wrapping at NUM_REQ, state->IDLE.
  - last_r=0: state->SEND.
- Latency figures:
  - req rising in IDLE with tx_empty=1: grant on edge 1, tx_latch high during the cycle after edge 2.
  - Minimum 4 cycles between successive tx_latch pulses, plus the UART byte time.
- Exactly one req_ack bit high per tx_latch pulse, coincident with it.
- req[g] dropping mid-message holds the grant (message continuity) unless the timeout fires.
- Single-byte message (req_last=1 on the first byte) is legal.
- Simultaneous requests with pointer=2 and req=4'b1011: order is 3, 0, 1.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter clears on entry to SEND and on each ack, and increments each SEND cycle with req[g]=0.
  - When it reaches TIMEOUT: timeout_err pulses for 1 cycle, grant_valid<=0, pointer<=(g+1) wrapped, state->IDLE.
  - A stall while waiting on tx_empty=0 does not count.
- Not defined: no counter; timeout_err tied 0; a stalled requester holds the grant indefinitely.

Test Plan:
- Single requester 0 sends 3 bytes 0xAA, 0xBB, 0xCC (last on 0xCC), UART model with 174-cycle baud divider -> exactly 3 tx_latch pulses carrying AA, BB, CC in order; grant_valid falls after final tx_empty; pointer=1.
- req=4'b1111 at once, each a 2-byte message -> grants 0, 1, 2, 3 in order; no interleaving; 8 latches total; pointer wraps to 0.
- Requester 3 mid-message while req[1] asserts -> requester 1 not acked until requester 3's last byte drains; then grant_idx=1.
- Reset asserted one cycle after a tx_latch -> all outputs 0 asynchronously; after release, req[2] alone grants 2 with pointer=0 scan.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=100, requester 1 sends one non-last byte then drops req -> timeout_err pulse at stall cycle 100, grant released, pending req[2] granted next. Without the macro -> grant held, no pulse after 1000 cycles.
